// File: rtl/axis_header_arbiter_if.sv
// Header-request / header-insert / output-snoop bundle for axis_header_arbiter.
// slave: the arbiter's view. master: the environment (requesters, inserter, snoop).
interface axis_header_arbiter_if #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int NUM_SRC      = 4
);
    // requester side
    logic [NUM_SRC-1:0]              src_valid;
    logic [NUM_SRC*DATA_WD-1:0]      src_header;
    logic [NUM_SRC*DATA_BYTE_WD-1:0] src_keep;
    logic [NUM_SRC-1:0]              src_ready;
    // header-insert port
    logic                            valid_insert;
    logic [DATA_WD-1:0]              header_insert;
    logic [DATA_BYTE_WD-1:0]         keep_insert;
    logic                            ready_insert;
    // inserter output-stream snoop
    logic                            mon_valid;
    logic                            mon_ready;
    logic                            mon_last;

    modport slave (
        input  src_valid, src_header, src_keep, ready_insert,
        input  mon_valid, mon_ready, mon_last,
        output src_ready, valid_insert, header_insert, keep_insert
    );

    modport master (
        output src_valid, src_header, src_keep, ready_insert,
        output mon_valid, mon_ready, mon_last,
        input  src_ready, valid_insert, header_insert, keep_insert
    );
endinterface

// File: rtl/axis_header_arbiter.sv
// Round-robin arbiter sharing one header-insert port among NUM_SRC requesters.
// Grants one header, offers it until accepted, then holds the grant until the
// inserter's output stream shows the packet's last beat.
module axis_header_arbiter #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int NUM_SRC      = 4,
    parameter int SEL_WD       = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
    parameter int CNT_WD       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    axis_header_arbiter_if.slave  bus,
    output logic [SEL_WD-1:0]     grant_id,
    output logic                  busy,
    output logic [CNT_WD-1:0]     pkt_count
);
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        OFFER    = 2'd1,
        WAIT_EOP = 2'd2
    } state_t;

    state_t                  state;
    logic [SEL_WD-1:0]       ptr;      // last served source; scan starts one past it
    logic [SEL_WD-1:0]       win;
    logic                    any_req;
    logic                    grant_fire;
    logic [NUM_SRC-1:0]      rdy;
    logic                    vld_q;
    logic [DATA_WD-1:0]      hdr_q;
    logic [DATA_BYTE_WD-1:0] keep_q;
    logic                    eop;

    // Round-robin pick: scanning from the far end lets the nearest requester
    // (ptr+1 first) overwrite any farther one.
    always_comb begin
        int idx;
        idx     = 0;
        win     = '0;
        any_req = 1'b0;
        for (int k = NUM_SRC; k >= 1; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_SRC) idx = idx - NUM_SRC;
            if (bus.src_valid[idx]) begin
                win     = SEL_WD'(idx);
                any_req = 1'b1;
            end
        end
    end

    // Accept strobe only in IDLE with enable, and never while reset is held.
    always_comb begin
        grant_fire = (state == IDLE) && enable && any_req && !rst;
        rdy        = '0;
        if (grant_fire) rdy[win] = 1'b1;
    end

    assign eop               = bus.mon_valid && bus.mon_ready && bus.mon_last;
    assign bus.src_ready     = rdy;
    assign bus.valid_insert  = vld_q;
    assign bus.header_insert = hdr_q;
    assign bus.keep_insert   = keep_q;

    // Grant / offer / wait-for-EOP sequencing with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= SEL_WD'(NUM_SRC - 1);
            vld_q     <= 1'b0;
            hdr_q     <= '0;
            keep_q    <= '0;
            grant_id  <= '0;
            busy      <= 1'b0;
            pkt_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_fire) begin
                        hdr_q    <= bus.src_header[int'(win)*DATA_WD +: DATA_WD];
                        keep_q   <= bus.src_keep[int'(win)*DATA_BYTE_WD +: DATA_BYTE_WD];
                        vld_q    <= 1'b1;
                        grant_id <= win;
                        busy     <= 1'b1;
                        state    <= OFFER;
                    end
                end
                OFFER: begin
                    if (bus.ready_insert) begin
                        vld_q <= 1'b0;
                        state <= WAIT_EOP;
                    end
                end
                WAIT_EOP: begin
                    if (eop) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        ptr       <= grant_id;
                        pkt_count <= pkt_count + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
